aes_inv_sr_state_buf: RTL

- Byte-serial receive buffer for the decrypt-side datapath; counterpart of the cipher-side `sa*_sr` ShiftRows state registers.
- Accepts 16 cipher-state bytes over a valid/ready stream, writes each byte into its InvShiftRows position, and presents the 128-bit state with a valid/ready handshake.
- Sits between the byte link and the inverse-round datapath. Single buffer, no overlap between fill and drain.

---
 rtl/aes_inv_sr_state_buf.sv | 133 +++++++++++++
 1 files changed

// File: rtl/aes_inv_sr_state_buf.sv
// Byte-serial InvShiftRows receive buffer for the decrypt datapath.
// Define AES_INV_SR_BYPASS_EN to add the sr_bypass straight-load port.
module aes_inv_sr_state_buf #(
  parameter bit ERR_STICKY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
`ifdef AES_INV_SR_BYPASS_EN
  input  logic         sr_bypass,
`endif
  output logic         err_len
);

  localparam int NBYTES = 16;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [7:0] r_mem [NBYTES];
  logic       r_err;

  logic       w_acc;
  logic       w_full;
  logic       w_len_err;
  logic       w_tail_err;
  logic       w_byp;
  logic [1:0] w_r;
  logic [1:0] w_c;
  logic [1:0] w_cs;
  logic [3:0] w_pos;

  assign w_acc      = in_valid && in_ready;
  assign w_full     = (r_cnt == 4'd15);
  assign w_len_err  = w_acc && in_last && !w_full;
  assign w_tail_err = w_acc && w_full && !in_last;

`ifdef AES_INV_SR_BYPASS_EN
  logic r_byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp <= 1'b0;
    end else if (w_acc && (r_cnt == 4'd0)) begin
      r_byp <= sr_bypass;
    end
  end

  // byte 0 sees the live input, later bytes the captured flag
  assign w_byp = (r_cnt == 4'd0) ? sr_bypass : r_byp;
`else
  assign w_byp = 1'b0;
`endif

  // row r is rotated right by r columns on the way in
  assign w_r   = r_cnt[1:0];
  assign w_c   = r_cnt[3:2];
  assign w_cs  = w_c + w_r;
  assign w_pos = w_byp ? r_cnt : {w_cs, w_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FILL: if (w_acc && w_full) w_state_nxt = S_HOLD;
      S_HOLD: if (out_ready) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_FILL: in_ready  = 1'b1;
      S_HOLD: out_valid = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_acc) begin
      r_cnt <= (w_full || in_last) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBYTES; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_acc) begin
      r_mem[w_pos] <= in_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_len_err || w_tail_err) begin
      r_err <= 1'b1;
    end else if (!ERR_STICKY || (w_acc && (r_cnt == 4'd0))) begin
      r_err <= 1'b0;
    end
  end

  assign err_len = r_err;

  for (genvar g = 0; g < NBYTES; g++) begin : g_out
    assign out_state[127-8*g -: 8] = r_mem[g];
  end

endmodule
